// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, occupancy count and a choice of
// registered-read or first-word-fall-through output.
module fifo_sync_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  if (!(FIFO_DEPTH >= 2 && AE_THRESH >= 1 && AE_THRESH < AF_THRESH &&
        AF_THRESH < FIFO_DEPTH)) begin : g_bad_params
    $fatal(1, "fifo_sync_param: need 1 <= AE_THRESH < AF_THRESH < FIFO_DEPTH, FIFO_DEPTH >= 2");
  end

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;

  // Flags are pure decodes of the occupancy counter.
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CNT_W'(AF_THRESH)) && !full;
  assign almostempty = (count_q <= CNT_W'(AE_THRESH)) && !empty;
  assign count       = count_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Next pointers wrap explicitly at the last entry; count moves only on write-only or read-only.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CNT_W'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
  end

  // Storage array; not cleared by reset, writes blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  // Pointers, counter and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
  end

  if (FWFT == 0) begin : g_std
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic                  rd_valid_q;

    // Registered read port: load the head word on an accepted read, otherwise hold.
    always_comb begin
      data_d = data_q;
      if (rd_acc) data_d = mem_q[rd_ptr_q];
    end

    // Read data register and its one-cycle valid strobe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        data_q     <= data_d;
        rd_valid_q <= rd_acc;
      end
    end

    assign data_out = data_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_fwft
    // Head word is always presented; rd_en pops it.
    assign data_out = mem_q[rd_ptr_q];
    assign rd_valid = !empty;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: three configurations (default
// registered-read 8-deep, 5-deep with custom thresholds, FWFT 8-deep) checked
// against a queue-based reference model plus constant vector tables.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        a_wr = 0, a_rd = 0;
  logic [15:0] a_din = '0, a_dout;
  logic        a_v, a_ack, a_ovf, a_unf, a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_cnt;
  // Instance B: depth 5, AF 3, AE 2
  logic        b_wr = 0, b_rd = 0;
  logic [15:0] b_din = '0, b_dout;
  logic        b_v, b_ack, b_ovf, b_unf, b_full, b_empty, b_af, b_ae;
  logic [2:0]  b_cnt;
  // Instance C: FWFT
  logic        c_wr = 0, c_rd = 0;
  logic [15:0] c_din = '0, c_dout;
  logic        c_v, c_ack, c_ovf, c_unf, c_full, c_empty, c_af, c_ae;
  logic [3:0]  c_cnt;

  fifo_sync_param u_a (
    .clk(clk), .rst(rst), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .data_out(a_dout), .rd_valid(a_v), .wr_ack(a_ack), .overflow(a_ovf),
    .underflow(a_unf), .full(a_full), .empty(a_empty), .almostfull(a_af),
    .almostempty(a_ae), .count(a_cnt));

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
    .data_out(b_dout), .rd_valid(b_v), .wr_ack(b_ack), .overflow(b_ovf),
    .underflow(b_unf), .full(b_full), .empty(b_empty), .almostfull(b_af),
    .almostempty(b_ae), .count(b_cnt));

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .data_in(c_din), .wr_en(c_wr), .rd_en(c_rd),
    .data_out(c_dout), .rd_valid(c_v), .wr_ack(c_ack), .overflow(c_ovf),
    .underflow(c_unf), .full(c_full), .empty(c_empty), .almostfull(c_af),
    .almostempty(c_ae), .count(c_cnt));

  typedef struct {
    logic [15:0] d;
    logic v, ack, ovf, unf, full, empty, af, ae;
    int   cnt;
  } obs_t;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] din;
    int          cnt;
    bit          ack;
    bit          ovf;
    bit          unf;
    bit          v;
    logic [15:0] dout;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int dep [3] = '{8, 5, 8};
  int afth[3] = '{7, 3, 7};
  int aeth[3] = '{1, 2, 1};
  bit fw  [3] = '{0, 0, 1};
  logic [15:0] last_d [3];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];
  obs_t o;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int msize(int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void mpush(int k, logic [15:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [15:0] mpop(int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic [15:0] mfront(int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void mreset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) last_d[i] = '0;
  endfunction

  function automatic obs_t get_obs(int k);
    obs_t r;
    case (k)
      0: begin
        r.d = a_dout; r.v = a_v; r.ack = a_ack; r.ovf = a_ovf; r.unf = a_unf;
        r.full = a_full; r.empty = a_empty; r.af = a_af; r.ae = a_ae; r.cnt = int'(a_cnt);
      end
      1: begin
        r.d = b_dout; r.v = b_v; r.ack = b_ack; r.ovf = b_ovf; r.unf = b_unf;
        r.full = b_full; r.empty = b_empty; r.af = b_af; r.ae = b_ae; r.cnt = int'(b_cnt);
      end
      default: begin
        r.d = c_dout; r.v = c_v; r.ack = c_ack; r.ovf = c_ovf; r.unf = c_unf;
        r.full = c_full; r.empty = c_empty; r.af = c_af; r.ae = c_ae; r.cnt = int'(c_cnt);
      end
    endcase
    return r;
  endfunction

  task automatic set_in(int k, bit wr, bit rd, logic [15:0] din);
    a_wr = (k == 0) && wr; a_rd = (k == 0) && rd; a_din = din;
    b_wr = (k == 1) && wr; b_rd = (k == 1) && rd; b_din = din;
    c_wr = (k == 2) && wr; c_rd = (k == 2) && rd; c_din = din;
  endtask

  // One clock with the given request on instance k, checked against the queue model.
  task automatic do_cycle(int k, bit wr, bit rd, logic [15:0] din);
    int s;
    bit wa, ra, eovf, eunf, ev;
    logic [15:0] pv;
    pv = '0;
    set_in(k, wr, rd, din);
    @(posedge clk);
    #1;
    s    = msize(k);
    wa   = wr && (s < dep[k]);
    ra   = rd && (s > 0);
    eovf = wr && (s == dep[k]);
    eunf = rd && (s == 0);
    if (ra) pv = mpop(k);
    if (wa) mpush(k, din);
    s = msize(k);
    if (fw[k]) ev = (s > 0);
    else begin
      ev = ra;
      if (ra) last_d[k] = pv;
    end
    o = get_obs(k);
    chk($sformatf("k%0d count", k), 32'(o.cnt), 32'(s));
    chk($sformatf("k%0d wr_ack", k), 32'(o.ack), 32'(wa));
    chk($sformatf("k%0d overflow", k), 32'(o.ovf), 32'(eovf));
    chk($sformatf("k%0d underflow", k), 32'(o.unf), 32'(eunf));
    chk($sformatf("k%0d full", k), 32'(o.full), 32'(s == dep[k]));
    chk($sformatf("k%0d empty", k), 32'(o.empty), 32'(s == 0));
    chk($sformatf("k%0d almostfull", k), 32'(o.af), 32'(s >= afth[k] && s < dep[k]));
    chk($sformatf("k%0d almostempty", k), 32'(o.ae), 32'(s > 0 && s <= aeth[k]));
    chk($sformatf("k%0d rd_valid", k), 32'(o.v), 32'(ev));
    if (!fw[k]) chk($sformatf("k%0d data_out", k), 32'(o.d), 32'(last_d[k]));
    else if (s > 0) chk($sformatf("k%0d fwft data_out", k), 32'(o.d), 32'(mfront(k)));
    set_in(k, 0, 0, '0);
  endtask

  vec_t tbl [18];

  initial begin
    mreset();
    // Table for instance A: fill with overflow, then drain with underflow.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b0, 16'(i + 1), i + 1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[8] = '{1'b1, 1'b0, 16'hDEAD, 8, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    for (int j = 0; j < 8; j++)
      tbl[9 + j] = '{1'b0, 1'b1, 16'h0000, 7 - j, 1'b0, 1'b0, 1'b0, 1'b1, 16'(j + 1)};
    tbl[17] = '{1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    o = get_obs(0);
    chk("rst count", 32'(o.cnt), 32'd0);
    chk("rst empty", 32'(o.empty), 32'd1);
    chk("rst full", 32'(o.full), 32'd0);
    chk("rst af", 32'(o.af), 32'd0);
    chk("rst ae", 32'(o.ae), 32'd0);
    chk("rst rd_valid", 32'(o.v), 32'd0);
    chk("rst flags", 32'({o.ack, o.ovf, o.unf}), 32'd0);
    chk("rst data_out", 32'(o.d), 32'd0);
    o = get_obs(2);
    chk("rst fwft rd_valid", 32'(o.v), 32'd0);
    rst = 1'b0;

    // Async reset in the middle of a burst
    for (int i = 0; i < 5; i++) do_cycle(0, 1, 0, 16'h0100 + 16'(i));
    chk("burst count", 32'(o.cnt), 32'd5);
    a_wr = 1'b1; a_din = 16'h0777;
    #1 rst = 1'b1;
    #1;
    o = get_obs(0);
    chk("async rst count", 32'(o.cnt), 32'd0);
    chk("async rst empty", 32'(o.empty), 32'd1);
    chk("async rst wr_ack", 32'(o.ack), 32'd0);
    @(posedge clk);
    #1;
    o = get_obs(0);
    chk("write under rst ignored", 32'(o.cnt), 32'd0);
    a_wr = 1'b0;
    rst = 1'b0;
    mreset();
    do_cycle(0, 0, 1, '0);
    chk("post-rst underflow", 32'(o.unf), 32'd1);

    // Table-driven fill/drain
    for (int i = 0; i < 18; i++) begin
      do_cycle(0, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("tbl%0d count", i), 32'(o.cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d ack", i), 32'(o.ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d ovf", i), 32'(o.ovf), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d unf", i), 32'(o.unf), 32'(tbl[i].unf));
      chk($sformatf("tbl%0d rd_valid", i), 32'(o.v), 32'(tbl[i].v));
      chk($sformatf("tbl%0d data", i), 32'(o.d), 32'(tbl[i].dout));
      chk($sformatf("tbl%0d full", i), 32'(o.full), 32'(tbl[i].cnt == 8));
      chk($sformatf("tbl%0d af", i), 32'(o.af), 32'(tbl[i].cnt == 7));
      chk($sformatf("tbl%0d ae", i), 32'(o.ae), 32'(tbl[i].cnt == 1));
    end

    // Simultaneous read and write corner cases
    do_cycle(0, 1, 1, 16'h0011);
    chk("both empty count", 32'(o.cnt), 32'd1);
    chk("both empty unf", 32'(o.unf), 32'd1);
    for (int i = 0; i < 7; i++) do_cycle(0, 1, 0, 16'h0012 + 16'(i));
    do_cycle(0, 1, 1, 16'h0099);
    chk("both full count", 32'(o.cnt), 32'd7);
    chk("both full ovf", 32'(o.ovf), 32'd1);
    chk("both full data", 32'(o.d), 32'h0011);
    repeat (3) do_cycle(0, 0, 1, '0);
    do_cycle(0, 1, 1, 16'h0055);
    chk("both mid count", 32'(o.cnt), 32'd4);
    chk("both mid ack", 32'(o.ack), 32'd1);
    chk("both mid data", 32'(o.d), 32'h0015);
    for (int i = 0; i < 40; i++)
      do_cycle(0, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50, 16'($urandom));

    // Depth-5 instance: directed fill/drain then random interleaving across wraps
    for (int i = 0; i < 6; i++) do_cycle(1, 1, 0, 16'h0200 + 16'(i));
    for (int i = 0; i < 6; i++) do_cycle(1, 0, 1, '0);
    for (int i = 0; i < 80; i++)
      do_cycle(1, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 16'($urandom));

    // FWFT instance
    do_cycle(2, 1, 0, 16'h00AA);
    chk("fwft show valid", 32'(o.v), 32'd1);
    chk("fwft show data", 32'(o.d), 32'h00AA);
    do_cycle(2, 0, 1, '0);
    chk("fwft pop empty", 32'(o.empty), 32'd1);
    chk("fwft pop valid", 32'(o.v), 32'd0);
    for (int i = 0; i < 60; i++)
      do_cycle(2, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
